// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider result types, beat encoding and widths
package div_pkg;

    localparam int DIV_TAG_W  = 4;
    localparam int DIV_DATA_W = 32;

    // LO carries the quotient, HI the remainder; LO is always broadcast first.
    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_e;

    typedef struct packed {
        logic [DIV_TAG_W-1:0]  tag;
        logic [DIV_DATA_W-1:0] q;
        logic [DIV_DATA_W-1:0] r;
    } div_result_t;

    function automatic int result_w(input int tag_w);
        return tag_w + 2 * DIV_DATA_W;
    endfunction

endpackage

// File: rtl/div_cdb_buffer_if.sv
// rtl/div_cdb_buffer_if.sv - divider result input and CDB beat output bundle
interface div_cdb_buffer_if
    import div_pkg::*;
#(
    parameter int TAG_W = DIV_TAG_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [TAG_W-1:0]      in_tag;
    logic [DIV_DATA_W-1:0] in_q;
    logic [DIV_DATA_W-1:0] in_r;

    logic                  cdb_req;
    logic                  cdb_grant;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DIV_DATA_W-1:0] cdb_val;
    logic                  cdb_hilo;
    logic                  cdb_last;

    // master: divider plus CDB arbiter side; slave: the buffer itself
    modport master (
        output in_valid, in_tag, in_q, in_r, cdb_grant,
        input  in_ready, cdb_req, cdb_tag, cdb_val, cdb_hilo, cdb_last
    );

    modport slave (
        input  in_valid, in_tag, in_q, in_r, cdb_grant,
        output in_ready, cdb_req, cdb_tag, cdb_val, cdb_hilo, cdb_last
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic registered FIFO with occupancy count and synchronous clear
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/div_cdb_buffer.sv
// rtl/div_cdb_buffer.sv - buffers divider results and broadcasts each as LO then HI CDB beats
module div_cdb_buffer
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    div_cdb_buffer_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int ENT_W = result_w(TAG_W);

    logic             clear;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             fire;
    logic [ENT_W-1:0] wdata;
    logic [ENT_W-1:0] rdata;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      head_q;
    logic [31:0]      head_r;
    beat_e            state;
    beat_e            state_next;

    assign clear = reset || flush;

    // No same-cycle bypass: a full buffer refuses even while the HI beat pops.
    assign bus.in_ready = !full && !reset;
    assign push         = bus.in_valid && bus.in_ready && !flush;
    assign wdata        = {bus.in_tag, bus.in_q, bus.in_r};

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_tag = rdata[ENT_W-1 -: TAG_W];
    assign head_q   = rdata[63:32];
    assign head_r   = rdata[31:0];

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= BEAT_LO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        fire       = bus.cdb_req && bus.cdb_grant;
        if (fire) begin
            if (state == BEAT_LO) begin
                state_next = BEAT_HI;
            end else begin
                state_next = BEAT_LO;
                pop        = 1'b1;
            end
        end
    end

    // Beat outputs come from the head entry and state only, never from cdb_grant.
    always_comb begin
        bus.cdb_req  = !empty;
        bus.cdb_tag  = '0;
        bus.cdb_val  = '0;
        bus.cdb_hilo = 1'b0;
        bus.cdb_last = 1'b0;
        if (!empty) begin
            bus.cdb_tag  = head_tag;
            bus.cdb_val  = (state == BEAT_HI) ? head_r : head_q;
            bus.cdb_hilo = (state == BEAT_HI);
            bus.cdb_last = (state == BEAT_HI);
        end
    end

endmodule

// File: tb/tb_div_cdb_buffer.sv
// tb/tb_div_cdb_buffer.sv - randomized and directed bench for div_cdb_buffer against a queue model
module tb_div_cdb_buffer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;

    div_cdb_buffer_if #(.TAG_W(TAG_W)) bus ();

    div_cdb_buffer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      q;
        logic [31:0]      r;
    } ent_t;

    ent_t mq[$];
    bit   mhi;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        logic        req;
        logic [31:0] val;
        req = (mq.size() > 0);
        val = !req ? 32'h0 : (mhi ? mq[0].r : mq[0].q);
        check("cdb_req",  bus.cdb_req,  req);
        check("cdb_tag",  bus.cdb_tag,  req ? mq[0].tag : '0);
        check("cdb_val",  bus.cdb_val,  val);
        check("cdb_hilo", bus.cdb_hilo, req && mhi);
        check("cdb_last", bus.cdb_last, req && mhi);
        check("count",    count,        mq.size());
        check("in_ready", bus.in_ready, (mq.size() < DEPTH) && !reset);
    endtask

    // Drive one cycle's inputs, advance the model past the coming edge, then check at negedge.
    task automatic tick(input logic v, input logic [TAG_W-1:0] t, input logic [31:0] q,
                        input logic [31:0] r, input logic g, input logic f, input logic rs,
                        output logic acc);
        bit rdy;
        bus.in_valid  = v;
        bus.in_tag    = t;
        bus.in_q      = q;
        bus.in_r      = r;
        bus.cdb_grant = g;
        flush         = f;
        reset         = rs;
        acc           = 1'b0;
        if (rs || f) begin
            mq.delete();
            mhi = 0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (g && mq.size() > 0) begin
                if (mhi) begin
                    void'(mq.pop_front());
                    mhi = 0;
                end else begin
                    mhi = 1;
                end
            end
            if (v && rdy) begin
                mq.push_back('{t, q, r});
                acc = 1'b1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic push1(input logic [TAG_W-1:0] t, input logic g);
        logic acc;
        tick(1'b1, t, $urandom, $urandom, g, 1'b0, 1'b0, acc);
    endtask

    task automatic idle(input logic g);
        logic acc;
        tick(1'b0, '0, '0, '0, g, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() > 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        check("drain_bound", mq.size(), 0);
    endtask

    logic             acc;
    logic             pv;
    logic [TAG_W-1:0] pt;
    logic [31:0]      pq;
    logic [31:0]      pr;
    logic             g;
    logic             f;
    logic             rs;
    int               n;

    initial begin
        mhi = 0;
        tick(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, acc);
        check("rst_req",   bus.cdb_req,  0);
        check("rst_val",   bus.cdb_val,  0);
        check("rst_ready", bus.in_ready, 0);
        idle(1'b0);
        check("post_rst_ready", bus.in_ready, 1);

        tick(1'b1, 4'd3, 32'd7, 32'd1, 1'b0, 1'b0, 1'b0, acc);
        check("single_lo_req",  bus.cdb_req,  1);
        check("single_lo_hilo", bus.cdb_hilo, 0);
        check("single_lo_val",  bus.cdb_val,  7);
        idle(1'b1);
        check("single_hi_val",  bus.cdb_val,  1);
        check("single_hi_last", bus.cdb_last, 1);
        idle(1'b1);
        check("single_done_req",   bus.cdb_req, 0);
        check("single_done_count", count,       0);

        for (int i = 0; i < 4; i++) push1(4'(i + 8), 1'b0);
        check("fill_count", count,        4);
        check("fill_ready", bus.in_ready, 0);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            tick(1'b1, 4'd12, 32'hC0, 32'hC1, 1'b1, 1'b0, 1'b0, acc);
            n++;
        end
        check("fill_accept_ticks", n, 3);
        check("fill_refill_count", count, 4);
        drain();

        push1(4'd1, 1'b0);
        push1(4'd2, 1'b0);
        idle(1'b1);
        push1(4'd4, 1'b1);
        check("concurrent_count", count, 2);
        drain();

        push1(4'd1, 1'b0);
        push1(4'd2, 1'b0);
        push1(4'd4, 1'b1);
        check("flush_pre_hilo", bus.cdb_hilo, 1);
        tick(1'b1, 4'd9, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0, acc);
        check("flush_count", count,       0);
        check("flush_req",   bus.cdb_req, 0);
        push1(4'd6, 1'b0);
        check("flush_then_lo", bus.cdb_hilo, 0);
        drain();

        push1(4'd7, 1'b0);
        push1(4'd2, 1'b1);
        tick(1'b1, 4'd11, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1, acc);
        check("midrst_req",   bus.cdb_req, 0);
        check("midrst_count", count,       0);
        tick(1'b1, 4'd5, 32'h55, 32'h66, 1'b0, 1'b0, 1'b0, acc);
        check("rst_push_tag_lo", bus.cdb_tag, 5);
        check("rst_push_val_lo", bus.cdb_val, 32'h55);
        idle(1'b1);
        check("rst_push_tag_hi", bus.cdb_tag, 5);
        check("rst_push_val_hi", bus.cdb_val, 32'h66);
        drain();

        pv = 1'b0;
        pt = '0;
        pq = '0;
        pr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pv && ($urandom % 10) < 6) begin
                pv = 1'b1;
                pt = TAG_W'($urandom);
                pq = $urandom;
                pr = $urandom;
            end
            g  = ($urandom % 2) == 0;
            f  = ($urandom % 50) == 0;
            rs = ($urandom % 100) == 0;
            tick(pv, pt, pq, pr, g, f, rs, acc);
            if (acc || f || rs) pv = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
